// File: rtl/uart_pkg.sv
// ============================================================
// uart_pkg : shared UART types and helpers (receiver and future transmitter)
// Revision 1.0
// ============================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // ones_xor is the XOR of all data bits and the received parity bit
    function automatic logic parity_error(input parity_t mode, input logic ones_xor);
        case (mode)
            PARITY_ODD:  return ~ones_xor;
            PARITY_EVEN: return ones_xor;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================
// uart_rx_sync : reset-to-1 synchronizer chain for the serial line
// Revision 1.0
// ============================================================
`default_nettype none

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_sync,
    output logic primed
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic [SYNC_STAGES-1:0] r_fill;

    // r_fill tracks when the chain output reflects the pin rather than the
    // reset value, so a line held low through reset never looks idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '1;
            r_fill  <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], rx_async};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rx_sync = r_chain[SYNC_STAGES-1];
    assign primed  = r_fill[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_frame_receiver.sv
// ============================================================
// uart_frame_receiver : parametrised UART receiver, valid/ready word output
// Revision 1.0
// ============================================================
`default_nettype none

module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 10000,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PARITY_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_term       = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_m1    = CW'(HALF - 1);
    localparam logic [IW-1:0] c_last_bit   = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] c_last_stop  = IW'(STOP_BITS - 1);

    logic w_rx;
    logic w_primed;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .rx_async (uart_rx),
        .rx_sync  (w_rx),
        .primed   (w_primed)
    );

    rx_state_t              r_state;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_armed;
    logic                   r_perr_pend;
    logic                   r_ferr_pend;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_ovr;
    logic                   r_busy;

    logic w_tick;
    logic w_commit;

    assign w_tick   = (r_cnt == c_term);
    assign w_commit = (r_state == RX_STOP) && w_tick && (r_idx == c_last_stop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_rx && w_primed) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && !w_rx) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_half_m1) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state     <= RX_DATA;
                            r_idx       <= '0;
                            r_perr_pend <= 1'b0;
                            r_ferr_pend <= 1'b0;
                        end else begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_last_bit) begin
                            r_idx   <= '0;
                            r_state <= (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_tick) begin
                        r_cnt       <= '0;
                        r_idx       <= '0;
                        r_perr_pend <= parity_error(PARITY, (^r_shift) ^ w_rx);
                        r_state     <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_ferr_pend <= 1'b1;
                        end
                        if (r_idx == c_last_stop) begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A commit wins over a same-cycle handshake: the old word is consumed
            // and the new one loads without flagging overrun.
            if (w_commit) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= r_perr_pend;
                r_ferr  <= r_ferr_pend | ~w_rx;
                r_ovr   <= r_valid && !ready;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
// ============================================================
// tb_uart_frame_receiver : directed bench for 8N1, 8E1 and 7O2 receivers
// Revision 1.0
// ============================================================
`default_nettype none

module tb_uart_frame_receiver
    import uart_pkg::*;
;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx_pin;
    logic [2:0] rdy;

    wire  [7:0] data0;
    wire  [7:0] data1;
    wire  [6:0] data2;
    wire  [2:0] vld;
    wire  [2:0] pe;
    wire  [2:0] fe;
    wire  [2:0] ov;
    wire  [2:0] bsy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         start_cyc [3];
    int         rise_cyc  [3];
    int         vcnt      [3];
    logic [8:0] cap_data  [3];
    logic [2:0] cap_pe;
    logic [2:0] cap_fe;
    logic [2:0] cap_ov;
    logic [2:0] pv;
    logic [8:0] dat       [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_receiver #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (PARITY_NONE),
        .STOP_BITS (1), .SYNC_STAGES (2)
    ) u_dut0 (
        .clk (clk), .reset (reset), .uart_rx (rx_pin[0]), .data (data0),
        .valid (vld[0]), .ready (rdy[0]), .parity_err (pe[0]),
        .frame_err (fe[0]), .overrun (ov[0]), .busy (bsy[0])
    );

    uart_frame_receiver #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (PARITY_EVEN),
        .STOP_BITS (1), .SYNC_STAGES (2)
    ) u_dut1 (
        .clk (clk), .reset (reset), .uart_rx (rx_pin[1]), .data (data1),
        .valid (vld[1]), .ready (rdy[1]), .parity_err (pe[1]),
        .frame_err (fe[1]), .overrun (ov[1]), .busy (bsy[1])
    );

    uart_frame_receiver #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY (PARITY_ODD),
        .STOP_BITS (2), .SYNC_STAGES (2)
    ) u_dut2 (
        .clk (clk), .reset (reset), .uart_rx (rx_pin[2]), .data (data2),
        .valid (vld[2]), .ready (rdy[2]), .parity_err (pe[2]),
        .frame_err (fe[2]), .overrun (ov[2]), .busy (bsy[2])
    );

    always_comb begin
        dat[0] = {1'b0, data0};
        dat[1] = {1'b0, data1};
        dat[2] = {2'b00, data2};
    end

    // Snapshot each word while valid is high, and note the cycle valid rises
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) begin
                vcnt[i]     <= vcnt[i] + 1;
                cap_data[i] <= dat[i];
                cap_pe[i]   <= pe[i];
                cap_fe[i]   <= fe[i];
                cap_ov[i]   <= ov[i];
            end
            if (vld[i] && !pv[i]) rise_cyc[i] <= cyc;
            pv[i] <= vld[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] word, input int nbits,
                              input bit has_par, input logic par,
                              input logic [1:0] stops, input int nstop);
        logic [15:0] v;
        int          n;
        v = '1;
        n = 0;
        v[n] = 1'b0;
        n++;
        for (int i = 0; i < nbits; i++) begin
            v[n] = word[i];
            n++;
        end
        if (has_par) begin
            v[n] = par;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            v[n] = stops[i];
            n++;
        end
        @(posedge clk);
        #1;
        start_cyc[sel] = cyc;
        for (int i = 0; i < n; i++) begin
            rx_pin[sel] = v[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_pin[sel] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0;

    initial begin
        reset  = 1'b1;
        rx_pin = 3'b111;
        rdy    = 3'b111;
        pv     = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, data0}, 32'h0);
        check("rst_valid", {29'd0, vld},   32'h0);
        check("rst_busy",  {29'd0, bsy},   32'h0);
        check("rst_perr",  {29'd0, pe},    32'h0);
        check("rst_ferr",  {29'd0, fe},    32'h0);
        check("rst_ovr",   {29'd0, ov},    32'h0);
        reset = 1'b0;
        idle(20);

        // 8N1 0xA5: latency from pin edge is SYNC_STAGES + 153
        v0 = vcnt[0];
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b01, 1);
        idle(4);
        check("a5_latency", rise_cyc[0] - start_cyc[0], 155);
        check("a5_vcycles", vcnt[0] - v0, 1);
        check("a5_data",    {23'd0, cap_data[0]}, 32'hA5);
        check("a5_perr",    {31'd0, cap_pe[0]}, 32'h0);
        check("a5_ferr",    {31'd0, cap_fe[0]}, 32'h0);
        check("a5_ovr",     {31'd0, cap_ov[0]}, 32'h0);
        check("a5_busy",    {31'd0, bsy[0]}, 32'h0);

        // 8E1 0x03: parity bit 1 is wrong, parity bit 0 is right
        v0 = vcnt[1];
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 2'b01, 1);
        idle(4);
        check("e1_bad_data", {23'd0, cap_data[1]}, 32'h03);
        check("e1_bad_perr", {31'd0, cap_pe[1]}, 32'h1);
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 2'b01, 1);
        idle(4);
        check("e1_ok_data",  {23'd0, cap_data[1]}, 32'h03);
        check("e1_ok_perr",  {31'd0, cap_pe[1]}, 32'h0);
        check("e1_words",    vcnt[1] - v0, 2);

        // 7O2 0x55: second stop bit low gives a framing error
        v0 = vcnt[2];
        send_frame(2, 9'h055, 7, 1'b1, 1'b1, 2'b01, 2);
        idle(3 * CPB);
        check("o2_fe_data", {23'd0, cap_data[2]}, 32'h55);
        check("o2_fe_ferr", {31'd0, cap_fe[2]}, 32'h1);
        check("o2_fe_perr", {31'd0, cap_pe[2]}, 32'h0);
        send_frame(2, 9'h02A, 7, 1'b1, 1'b0, 2'b11, 2);
        idle(4);
        check("o2_ok_data", {23'd0, cap_data[2]}, 32'h2A);
        check("o2_ok_ferr", {31'd0, cap_fe[2]}, 32'h0);
        check("o2_words",   vcnt[2] - v0, 2);

        // Overrun: two words with no consumer, then accept
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b01, 1);
        check("ov1_valid", {31'd0, vld[0]}, 32'h1);
        check("ov1_data",  {24'd0, data0}, 32'h11);
        check("ov1_ovr",   {31'd0, ov[0]}, 32'h0);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b01, 1);
        check("ov2_valid", {31'd0, vld[0]}, 32'h1);
        check("ov2_data",  {24'd0, data0}, 32'h22);
        check("ov2_ovr",   {31'd0, ov[0]}, 32'h1);
        rdy[0] = 1'b1;
        idle(1);
        check("ack_valid", {31'd0, vld[0]}, 32'h0);
        check("ack_ovr",   {31'd0, ov[0]}, 32'h0);
        check("ack_data",  {24'd0, data0}, 32'h22);

        // Glitch of HALF-2 cycles is rejected
        v0 = vcnt[0];
        rx_pin[0] = 1'b0;
        idle(5);
        check("gl_busy_hi", {31'd0, bsy[0]}, 32'h1);
        idle(1);
        rx_pin[0] = 1'b1;
        idle(2 * CPB);
        check("gl_busy_lo", {31'd0, bsy[0]}, 32'h0);
        check("gl_words",   vcnt[0] - v0, 0);

        // Reset at data bit 4 with the line held low
        rx_pin[0] = 1'b0;
        idle(CPB);
        rx_pin[0] = 1'b1;
        idle(4 * CPB);
        rx_pin[0] = 1'b0;
        idle(CPB / 2);
        check("rm_busy_pre", {31'd0, bsy[0]}, 32'h1);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        check("rm_data",  {24'd0, data0}, 32'h0);
        check("rm_valid", {31'd0, vld[0]}, 32'h0);
        check("rm_busy",  {31'd0, bsy[0]}, 32'h0);
        v0 = vcnt[0];
        idle(3 * CPB);
        check("rm_no_start", {31'd0, bsy[0]}, 32'h0);
        rx_pin[0] = 1'b1;
        idle(CPB);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b01, 1);
        idle(4);
        check("rm_words", vcnt[0] - v0, 1);
        check("rm_3c",    {23'd0, cap_data[0]}, 32'h3C);
        check("rm_ferr",  {31'd0, cap_fe[0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
